// File: rtl/core2_result_writeback.sv
// Core2 result writeback: pops a result and its delayed opcode together and commits the
// result to the register file, the intermediate-result FIFO or RAM D.
module core2_result_writeback #(
  parameter int DATA        = 256,
  parameter int ADDR        = 2,
  parameter int OPCODE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   res_empty,
  output logic                   res_rd_en,
  input  logic [DATA-1:0]        res_data,
  input  logic                   op_empty,
  output logic                   op_rd_en,
  input  logic [OPCODE_SIZE-1:0] op_data,
  output logic                   reg_wr_en,
  output logic [2:0]             reg_sel,
  output logic [DATA-1:0]        reg_data,
  output logic                   tmp_wr_en,
  output logic [DATA-1:0]        tmp_data,
  input  logic                   tmp_full,
  output logic                   w_D,
  output logic [ADDR-1:0]        adbus_D,
  output logic [DATA-1:0]        data_out_D,
  output logic                   busy,
  output logic [7:0]             wb_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    STALL,
    COMMIT
  } state_t;

  localparam logic [2:0] DEST_DISCARD = 3'b000;
  localparam logic [2:0] DEST_TMP     = 3'b110;
  localparam logic [2:0] DEST_RAMD    = 3'b111;

  state_t          state_reg;
  logic [DATA-1:0] res_hold_reg;
  logic [2:0]      dest_reg;
  logic [1:0]      addr_reg;
  logic            pop_ok;
  logic            commit_go;
  logic            unused_op;

  // Only the destination and address fields of the opcode matter here.
  assign unused_op = ^{op_data[OPCODE_SIZE-1:9], op_data[5:3], op_data[0]};

  assign pop_ok = !res_empty && !op_empty;

  // The commit decision is taken one cycle before the sink sees its strobe.
  assign commit_go = ((state_reg == DECODE) && !((dest_reg == DEST_TMP) && tmp_full)) ||
                     ((state_reg == STALL) && !tmp_full);

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      res_hold_reg <= '0;
      dest_reg     <= '0;
      addr_reg     <= '0;
      res_rd_en    <= 1'b0;
      op_rd_en     <= 1'b0;
      reg_wr_en    <= 1'b0;
      reg_sel      <= '0;
      reg_data     <= '0;
      tmp_wr_en    <= 1'b0;
      tmp_data     <= '0;
      w_D          <= 1'b0;
      adbus_D      <= '0;
      data_out_D   <= '0;
      wb_count     <= '0;
    end else begin
      res_rd_en <= 1'b0;
      op_rd_en  <= 1'b0;
      reg_wr_en <= 1'b0;
      tmp_wr_en <= 1'b0;
      w_D       <= 1'b0;

      case (state_reg)
        IDLE: begin
          // The pop strobe is live this cycle; its data arrives in FETCH.
          if (res_rd_en) begin
            state_reg <= FETCH;
          end else if (pop_ok) begin
            res_rd_en <= 1'b1;
            op_rd_en  <= 1'b1;
          end
        end
        FETCH: begin
          res_hold_reg <= res_data;
          dest_reg     <= op_data[8:6];
          addr_reg     <= op_data[2:1];
          state_reg    <= DECODE;
        end
        DECODE: begin
          state_reg <= commit_go ? COMMIT : STALL;
        end
        STALL: begin
          if (commit_go) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          // Issuing the next pop here keeps throughput at one result per four cycles.
          state_reg <= IDLE;
          if (pop_ok) begin
            res_rd_en <= 1'b1;
            op_rd_en  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      if (commit_go) begin
        wb_count <= wb_count + 8'd1;
        if (dest_reg == DEST_TMP) begin
          tmp_wr_en <= 1'b1;
          tmp_data  <= res_hold_reg;
        end else if (dest_reg == DEST_RAMD) begin
          w_D        <= 1'b1;
          adbus_D    <= ADDR'(addr_reg);
          data_out_D <= res_hold_reg;
        end else if (dest_reg != DEST_DISCARD) begin
          reg_wr_en <= 1'b1;
          reg_sel   <= dest_reg;
          reg_data  <= res_hold_reg;
        end
      end
    end
  end

endmodule

// File: doc/core2_result_writeback.md
Name: core2_result_writeback

Overview:
- Consumer end of the Core2 multiplier path. It is the reader side of the Core2 output FIFO and of the 16-bit delayed-opcode FIFO that the sequencer fills when it issues a multiply.
- It pops one result and its matching opcode in lockstep, decodes the opcode destination field, and commits the result to one of three sinks: the working register file (A..E), the intermediate-result FIFO, or RAM D.
- It sits beside the sequencer and completes every Core2 operation the sequencer launched.

Parameters:
- DATA, 256, result width in bits.
- ADDR, 2, RAM D address width.
- OPCODE_SIZE, 16, opcode width; must be >= 9.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- res_empty  in  1  Core2 output FIFO empty (its Out_Busy).
- res_rd_en  out  1  pop Core2 output FIFO.
- res_data  in  DATA  Core2 output FIFO data; valid the cycle after res_rd_en.
- op_empty  in  1  delayed-opcode FIFO empty.
- op_rd_en  out  1  pop delayed-opcode FIFO.
- op_data  in  OPCODE_SIZE  delayed opcode; valid the cycle after op_rd_en.
- reg_wr_en  out  1  one-cycle write strobe to the A..E register file.
- reg_sel  out  3  register select (3'b001=A .. 3'b101=E).
- reg_data  out  DATA  register write data.
- tmp_wr_en  out  1  one-cycle push to the intermediate-result FIFO.
- tmp_data  out  DATA  push data.
- tmp_full  in  1  intermediate-result FIFO full (its In_Busy).
- w_D  out  1  one-cycle RAM D write strobe.
- adbus_D  out  ADDR  RAM D write address.
- data_out_D  out  DATA  RAM D write data.
- busy  out  1  high in any state other than IDLE.
- wb_count  out  8  committed-writeback counter; wraps at 255->0.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All strobes (res_rd_en, op_rd_en, reg_wr_en, tmp_wr_en, w_D) are 0. reg_sel, adbus_D and wb_count are 0. Data outputs are 0. busy=0.
- Reset mid-operation aborts the operation. An entry already popped is dropped and is not written to any sink.
- Opcode decode:
  - dest = op_data[8:6]; addr = op_data[2:1].
  - 3'b001..3'b101: register file.
  - 3'b110: intermediate FIFO.
  - 3'b111: RAM D at addr.
  - 3'b000: discard. The entry is consumed and counted, but no strobe is raised.
- FSM states: IDLE, FETCH, DECODE, STALL, COMMIT.
- IDLE: when res_empty=0 and op_empty=0 in the same cycle, assert res_rd_en=op_rd_en=1 for exactly one cycle, then go to FETCH. If only one FIFO is non-empty, wait in IDLE and pop nothing. The two FIFOs are never popped independently.
- FETCH: strobes are 0. res_data and op_data are valid in this cycle. Capture both into internal registers, then go to DECODE.
- DECODE:
  - If dest=3'b110 and tmp_full=1, go to STALL.
  - Otherwise go to COMMIT.
- STALL: hold the captured data. Go to COMMIT in the first cycle tmp_full=0.
- COMMIT: for exactly one cycle, drive the selected strobe with the matching data/select/address. Increment wb_count (mod 256). Return to IDLE.
  - Strobes are registered outputs. The sink sees the strobe during the cycle after the COMMIT decision.
  - At most one of reg_wr_en, tmp_wr_en, w_D is high in any cycle.
- Latency: a pop in cycle N produces a sink strobe in cycle N+3 when there is no stall. Throughput is 1 result per 4 cycles. The Core2 pipeline depth covers this.
- Between strobes, the data/select/address outputs hold their last driven values.
- Ordering: results commit strictly in FIFO order. Opcode k always pairs with result k.
- Empty FIFOs: no read is ever issued to an empty FIFO.
- Full sink: tmp_wr_en is never asserted while tmp_full=1. The register file and RAM D never stall.
- wb_count wraps from 255 to 0 with no flag.

Test Plan:
- Single RAM D writeback: push res=256'h1234, op=16'h01C4 (dest=111, addr=2'b10) -> w_D=1 for one cycle, adbus_D=2, data_out_D=256'h1234, exactly 3 cycles after res_rd_en; wb_count=1.
- Register file sweep: push 5 entries with dest 001..101 and data 1..5 -> reg_wr_en pulses 5 times, reg_sel=1..5 in order, reg_data matching each; no w_D or tmp_wr_en pulses.
- FIFO sink backpressure: dest=110, data=256'hABCD, tmp_full=1 held 6 cycles -> busy=1 and no tmp_wr_en during the stall; one tmp_wr_en with tmp_data=256'hABCD after tmp_full drops.
- Mismatched availability: op_empty=0, res_empty=1 for 10 cycles -> no pops and busy=0; release res_empty -> both rd_en rise in the same cycle and the commit proceeds.
- Discard and wrap: 256 entries with dest=000, then 1 entry with dest=111 -> no strobes during the first 256; wb_count reads 0 after entry 256, then 1 after the RAM D write.
- Reset mid-operation: drop rst_n low in the FETCH cycle -> no sink strobe follows; all outputs are 0 the next cycle; the FSM resumes from IDLE with the next FIFO entries.
